clk_sys_supervisor: RTL

- Sits directly downstream of the system PLL, in the 36.864 MHz clk_sys domain.
- Consumes the PLL lock indication and sequences a clean synchronous core reset.
- Generates the single-cycle clock enables used by the core: CPU 3.072 MHz, pixel 6.144 MHz, and a fractional sound-CPU enable of about 0.894886 MHz.
- All core logic runs on clk_sys and is gated by these enables; no derived clocks are produced.

---
 rtl/clk_sys_supervisor.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/clk_sys_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : clk_sys_supervisor
// Description : Reset sequencer and clock-enable generator for the clk_sys
//               (36.864 MHz) domain, directly downstream of the system PLL.
//               Synchronises PLL lock, holds the core in reset for
//               HOLD_CYCLES after lock or a soft reset, then produces the
//               single-cycle CPU, pixel and fractional sound enables.
// Ports       : clk_sys      - system clock (PLL output)
//               rst_n        - asynchronous active-low reset
//               pll_locked   - PLL lock, asynchronous to clk_sys
//               soft_reset   - synchronous core reset request (level/pulse)
//               core_reset_n - synchronous active-low core reset
//               ce_cpu       - one-cycle CPU enable (clk_sys / DIV_CPU)
//               ce_pix       - one-cycle pixel enable (clk_sys / DIV_PIX)
//               ce_snd       - one-cycle fractional sound enable
//               running      - high while the core is released
//               lock_lost    - sticky: lock dropped while running
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sys_supervisor #(
    parameter int HOLD_CYCLES = 1024,
    parameter int DIV_CPU     = 12,
    parameter int DIV_PIX     = 6,
    parameter int SND_NUM     = 894886,
    parameter int SND_DEN     = 36864000,
    parameter int ACC_W       = 27
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic soft_reset,
    output logic core_reset_n,
    output logic ce_cpu,
    output logic ce_pix,
    output logic ce_snd,
    output logic running,
    output logic lock_lost
);

    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_CPU_W  = $clog2(DIV_CPU + 1);
    localparam int c_PIX_W  = $clog2(DIV_PIX + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_CPU_W-1:0]  c_CPU_LAST  = c_CPU_W'(DIV_CPU - 1);
    localparam logic [c_PIX_W-1:0]  c_PIX_LAST  = c_PIX_W'(DIV_PIX - 1);
    localparam logic [ACC_W-1:0]    c_SND_NUM   = ACC_W'(SND_NUM);
    localparam logic [ACC_W-1:0]    c_SND_DEN   = ACC_W'(SND_DEN);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Lock synchroniser
    logic r_sync1;
    logic r_lk;

    // State and counters
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [c_CPU_W-1:0]  r_cpu_cnt;
    logic [c_CPU_W-1:0]  w_cpu_nxt;
    logic [c_PIX_W-1:0]  r_pix_cnt;
    logic [c_PIX_W-1:0]  w_pix_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-1:0]    w_sum_nxt;
    logic                r_lock_lost;
    logic                w_lock_lost_nxt;
    logic                w_run_nxt;
    logic                w_stay_run;

    // Registered outputs
    logic r_core_reset_n;
    logic r_ce_cpu;
    logic r_ce_pix;
    logic r_ce_snd;
    logic r_running;

    // ------------------------------------------------------------------
    // Next-state logic. Loss of lock outranks every other event.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold_cnt;
        w_lock_lost_nxt = r_lock_lost;

        if (!r_lk) begin
            w_state_nxt = ST_WAIT;
            w_hold_nxt  = '0;
            if (r_state == ST_RUN) begin
                w_lock_lost_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                ST_WAIT: begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = c_HOLD_LOAD;
                end
                ST_HOLD: begin
                    if (soft_reset) begin
                        w_hold_nxt = c_HOLD_LOAD;
                    end else if (r_hold_cnt == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_hold_nxt = r_hold_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (soft_reset) begin
                        w_state_nxt = ST_HOLD;
                        w_hold_nxt  = c_HOLD_LOAD;
                    end
                end
                default: begin
                    w_state_nxt = ST_WAIT;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Dividers and fractional accumulator advance only while RUN
    // persists; entering or leaving RUN restarts them from zero.
    // ------------------------------------------------------------------
    assign w_run_nxt  = (w_state_nxt == ST_RUN);
    assign w_stay_run = w_run_nxt && (r_state == ST_RUN);
    assign w_sum      = r_acc + c_SND_NUM;

    always_comb begin
        w_cpu_nxt = '0;
        w_pix_nxt = '0;
        w_acc_nxt = '0;
        if (w_stay_run) begin
            w_cpu_nxt = (r_cpu_cnt == c_CPU_LAST) ? '0 : r_cpu_cnt + 1'b1;
            w_pix_nxt = (r_pix_cnt == c_PIX_LAST) ? '0 : r_pix_cnt + 1'b1;
            w_acc_nxt = (w_sum >= c_SND_DEN) ? w_sum - c_SND_DEN : w_sum;
        end
    end

    // Enables are registered against the next-cycle counter values, so
    // each output is valid in the same cycle its counter shows DIV-1.
    assign w_sum_nxt = w_acc_nxt + c_SND_NUM;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1        <= 1'b0;
            r_lk           <= 1'b0;
            r_state        <= ST_WAIT;
            r_hold_cnt     <= '0;
            r_cpu_cnt      <= '0;
            r_pix_cnt      <= '0;
            r_acc          <= '0;
            r_lock_lost    <= 1'b0;
            r_core_reset_n <= 1'b0;
            r_ce_cpu       <= 1'b0;
            r_ce_pix       <= 1'b0;
            r_ce_snd       <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_sync1        <= pll_locked;
            r_lk           <= r_sync1;
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_cpu_cnt      <= w_cpu_nxt;
            r_pix_cnt      <= w_pix_nxt;
            r_acc          <= w_acc_nxt;
            r_lock_lost    <= w_lock_lost_nxt;
            r_core_reset_n <= w_run_nxt;
            r_running      <= w_run_nxt;
            r_ce_cpu       <= w_run_nxt && (w_cpu_nxt == c_CPU_LAST);
            r_ce_pix       <= w_run_nxt && (w_pix_nxt == c_PIX_LAST);
            r_ce_snd       <= w_run_nxt && (w_sum_nxt >= c_SND_DEN);
        end
    end

    assign core_reset_n = r_core_reset_n;
    assign ce_cpu       = r_ce_cpu;
    assign ce_pix       = r_ce_pix;
    assign ce_snd       = r_ce_snd;
    assign running      = r_running;
    assign lock_lost    = r_lock_lost;

endmodule
`default_nettype wire
